// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared opcode, ALU-op and control-bundle bit-index constants
//               for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU-control sub-decoder selector
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Packed control bundle layout
    localparam int CTRL_BITS       = 13;
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_MSB = 1;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_JUMP       = 8;
    localparam int CTRL_JALR       = 9;
    localparam int CTRL_LUI        = 10;
    localparam int CTRL_AUIPC      = 11;
    localparam int CTRL_ILLEGAL    = 12;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_opcode_decode
// Description : Purely combinational opcode-to-control table. Unlisted
//               opcodes (including compressed encodings) decode to a NOP
//               with the illegal flag raised; FENCE/SYSTEM are legal NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_opcode_decode
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic [1:0] alu_op,
    output logic       jump,
    output logic       jalr,
    output logic       lui,
    output logic       auipc,
    output logic       illegal
);

    // Decode table: every flag defaults low, each opcode raises its own set
    always_comb begin
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_op     = ALUOP_ADD;
        jump       = 1'b0;
        jalr       = 1'b0;
        lui        = 1'b0;
        auipc      = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            OP_IMM: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = ALUOP_ITYPE;
            end
            OP_LOAD: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_STORE: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = ALUOP_BRANCH;
            end
            OP_JAL: begin
                reg_write = 1'b1;
                jump      = 1'b1;
            end
            OP_JALR: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                jump      = 1'b1;
                jalr      = 1'b1;
            end
            OP_LUI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                lui       = 1'b1;
            end
            OP_AUIPC: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                auipc     = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule : rv32i_opcode_decode
`default_nettype wire

// File: rtl/rv32i_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_control_decoder
// Description : Decode-stage main control decoder. Same-cycle combinational
//               control plus a registered ID/EX copy with flush/stall and a
//               sticky illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_control_decoder
    import rv32i_pkg::*;
#(
    parameter int CTRL_W = CTRL_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic [1:0]        alu_op,
    output logic              jump,
    output logic              jalr,
    output logic              lui,
    output logic              auipc,
    output logic              illegal,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic              q_valid,
    output logic              illegal_sticky
);

    logic [CTRL_W-1:0] w_bundle;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;
    logic              r_sticky;

    rv32i_opcode_decode u_opcode_decode (
        .opcode     (opcode),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_op     (alu_op),
        .jump       (jump),
        .jalr       (jalr),
        .lui        (lui),
        .auipc      (auipc),
        .illegal    (illegal)
    );

    // Pack the decoded flags into the ID/EX bundle layout
    always_comb begin
        w_bundle                                  = '0;
        w_bundle[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = alu_op;
        w_bundle[CTRL_ALU_SRC]                    = alu_src;
        w_bundle[CTRL_MEM_TO_REG]                 = mem_to_reg;
        w_bundle[CTRL_REG_WRITE]                  = reg_write;
        w_bundle[CTRL_MEM_READ]                   = mem_read;
        w_bundle[CTRL_MEM_WRITE]                  = mem_write;
        w_bundle[CTRL_BRANCH]                     = branch;
        w_bundle[CTRL_JUMP]                       = jump;
        w_bundle[CTRL_JALR]                       = jalr;
        w_bundle[CTRL_LUI]                        = lui;
        w_bundle[CTRL_AUIPC]                      = auipc;
        w_bundle[CTRL_ILLEGAL]                    = illegal;
    end

    // ID/EX register: flush beats stall; an invalid slot loads an empty bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_ctrl  <= valid_in ? w_bundle : '0;
            r_valid <= valid_in & ~illegal;
        end
    end

    // Sticky illegal flag: observes every edge regardless of stall/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (valid_in && illegal) begin
            r_sticky <= 1'b1;
        end
    end

    assign ctrl_q         = r_ctrl;
    assign q_valid        = r_valid;
    assign illegal_sticky = r_sticky;

endmodule : rv32i_control_decoder
`default_nettype wire

// File: tb/tb_rv32i_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_control_decoder
// Description : Self-checking bench for rv32i_control_decoder: directed
//               steps followed by randomized opcode/valid/stall/flush traffic
//               checked against a table-driven reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_control_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic        alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic        jump, jalr, lui, auipc, illegal;
    logic [12:0] ctrl_q;
    logic        q_valid;
    logic        illegal_sticky;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference-model state for the registered stage
    logic [12:0] m_q;
    logic        m_v;
    logic        m_sticky;

    // Reference decode table, one row per legal opcode
    typedef struct {
        logic [6:0] op;
        logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [1:0] alu_op;
        logic       jump, jalr, lui, auipc;
    } row_t;

    row_t table_q[$];

    rv32i_control_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .valid_in       (valid_in),
        .stall          (stall),
        .flush          (flush),
        .alu_src        (alu_src),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .branch         (branch),
        .alu_op         (alu_op),
        .jump           (jump),
        .jalr           (jalr),
        .lui            (lui),
        .auipc          (auipc),
        .illegal        (illegal),
        .ctrl_q         (ctrl_q),
        .q_valid        (q_valid),
        .illegal_sticky (illegal_sticky)
    );

    always #5 clk = ~clk;

    function automatic void add_row(input logic [6:0] op, input logic [5:0] f,
                                    input logic [1:0] aop, input logic [3:0] x);
        row_t r;
        r.op = op;
        {r.alu_src, r.mem_to_reg, r.reg_write, r.mem_read, r.mem_write, r.branch} = f;
        r.alu_op = aop;
        {r.jump, r.jalr, r.lui, r.auipc} = x;
        table_q.push_back(r);
    endfunction

    // Expected bundle: table lookup, anything not in the table is illegal
    function automatic logic [12:0] model(input logic [6:0] op);
        logic [12:0] b;
        b = 13'h1000;
        foreach (table_q[i]) begin
            if (table_q[i].op == op) begin
                b = {1'b0, table_q[i].auipc, table_q[i].lui, table_q[i].jalr,
                     table_q[i].jump, table_q[i].branch, table_q[i].mem_write,
                     table_q[i].mem_read, table_q[i].reg_write,
                     table_q[i].mem_to_reg, table_q[i].alu_src, table_q[i].alu_op};
            end
        end
        return b;
    endfunction

    function automatic logic [12:0] observed_comb();
        return {illegal, auipc, lui, jalr, jump, branch, mem_write, mem_read,
                reg_write, mem_to_reg, alu_src, alu_op};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".ctrl_q"}, {3'b0, ctrl_q}, {3'b0, m_q});
        check({tag, ".q_valid"}, {15'b0, q_valid}, {15'b0, m_v});
        check({tag, ".sticky"}, {15'b0, illegal_sticky}, {15'b0, m_sticky});
    endtask

    // One clock step: drive away from the edge, check comb, advance model, check regs
    task automatic step(input string tag, input logic [6:0] op, input logic vin,
                        input logic st, input logic fl, input bit chk_comb);
        logic [12:0] b;
        @(negedge clk);
        opcode = op; valid_in = vin; stall = st; flush = fl;
        #1;
        b = model(op);
        if (chk_comb) check({tag, ".comb"}, {3'b0, observed_comb()}, {3'b0, b});
        @(posedge clk);
        if (vin && b[12]) m_sticky = 1'b1;
        if (fl) begin
            m_q = '0; m_v = 1'b0;
        end else if (!st) begin
            m_q = vin ? b : 13'h0;
            m_v = vin & ~b[12];
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [6:0] legal_ops [11];
        logic [6:0] op;
        logic [12:0] saved_q;

        add_row(7'b0110011, 6'b001000, 2'b10, 4'b0000);
        add_row(7'b0010011, 6'b101000, 2'b11, 4'b0000);
        add_row(7'b0000011, 6'b111100, 2'b00, 4'b0000);
        add_row(7'b0100011, 6'b100010, 2'b00, 4'b0000);
        add_row(7'b1100011, 6'b000001, 2'b01, 4'b0000);
        add_row(7'b1101111, 6'b001000, 2'b00, 4'b1000);
        add_row(7'b1100111, 6'b101000, 2'b00, 4'b1100);
        add_row(7'b0110111, 6'b101000, 2'b00, 4'b0010);
        add_row(7'b0010111, 6'b101000, 2'b00, 4'b0001);
        add_row(7'b0001111, 6'b000000, 2'b00, 4'b0000);
        add_row(7'b1110011, 6'b000000, 2'b00, 4'b0000);
        foreach (table_q[i]) legal_ops[i] = table_q[i].op;

        // Reset state, comb path alive during reset
        rst_n = 1'b0; opcode = 7'b0110011; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        m_q = '0; m_v = 1'b0; m_sticky = 1'b0;
        #4;
        check("rst.rtype_comb", {3'b0, observed_comb()}, 16'h0012);
        check("rst.alu_op", {14'b0, alu_op}, 16'h0002);
        @(posedge clk); #1;
        check_regs("rst");
        @(negedge clk); rst_n = 1'b1;

        // Directed comb sweep of each opcode class
        opcode = 7'b0000011; #1;
        check("load.mem_to_reg", {15'b0, mem_to_reg}, 16'h0001);
        check("load.comb", {3'b0, observed_comb()}, 16'h003C);
        opcode = 7'b0100011; #1;
        check("store.comb", {3'b0, observed_comb()}, 16'h0044);
        opcode = 7'b1100011; #1;
        check("branch.comb", {3'b0, observed_comb()}, 16'h0081);
        opcode = 7'b1100111; #1;
        check("jalr.comb", {3'b0, observed_comb()}, 16'h0314);
        opcode = 7'b0010011; #1;
        check("imm.alu_op", {14'b0, alu_op}, 16'h0003);
        opcode = 7'b1111100; #1;
        check("rvc_like.comb", {3'b0, observed_comb()}, 16'h1000);

        // Load, then stall holds, then flush+stall clears
        step("ld", 7'b0000011, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ld.ctrl_q_const", {3'b0, ctrl_q}, 16'h003C);
        saved_q = ctrl_q;
        step("stall", 7'b0100011, 1'b1, 1'b1, 1'b0, 1'b1);
        check("stall.hold_const", {3'b0, ctrl_q}, {3'b0, 13'h003C});
        step("flush_stall", 7'b0100011, 1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_stall.zero", {3'b0, ctrl_q}, 16'h0000);

        // Illegal opcode sets sticky; sticky survives later legal traffic
        step("ill", 7'b1111111, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ill.bit12", {15'b0, ctrl_q[12]}, 16'h0001);
        step("after_ill", 7'b0110011, 1'b1, 1'b0, 1'b0, 1'b1);
        check("after_ill.sticky", {15'b0, illegal_sticky}, 16'h0001);
        // Illegal seen while flushing still sets sticky (already set, exercised in random)

        // Async reset between edges while bundle is nonzero
        @(negedge clk); #2;
        rst_n = 1'b0;
        m_q = '0; m_v = 1'b0; m_sticky = 1'b0;
        #1;
        check_regs("async_rst");
        @(negedge clk); rst_n = 1'b1;

        // Illegal during flush sets sticky
        step("ill_flush", 7'b1011011, 1'b1, 1'b0, 1'b1, 1'b0);
        step("legal_after_rel", 7'b1101111, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 10)];
            else op = 7'($urandom);
            step("rnd", op, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rv32i_control_decoder
`default_nettype wire
